// File: rtl/sbox_bram_feeder.sv
// Feeds Boolean-masked bytes to a dual-port S-box BRAM (one share per port) and
// carries each byte's valid/index alongside the fixed two-cycle BRAM read latency.
module sbox_bram_feeder #(
  parameter int NBYTES = 16,
  parameter int LAT    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_sh0,
  input  logic [7:0] in_sh1,
  input  logic [1:0] in_tsel,
  output logic [9:0] addra,
  output logic [9:0] addrb,
  output logic       bram_en,
  output logic       bram_rst,
  input  logic [7:0] doa,
  input  logic [7:0] dob,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sh0,
  output logic [7:0] out_sh1,
  output logic [3:0] out_idx,
  output logic       out_last,
  output logic [1:0] dbg_state,
  output logic [4:0] dbg_issued
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [4:0] NB5      = 5'(NBYTES);
  localparam logic [3:0] LAST_IDX = 4'(NBYTES - 1);

  state_t         state_q;
  state_t         state_d;
  logic [4:0]     issued;
  logic [LAT-1:0] vld;
  logic [3:0]     idx_pipe [LAT];
  logic           v2;
  logic           stall;
  logic           adv;
  logic           accept;
  logic           out_hs;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and a raised out_valid holds its
  // payload until out_ready completes the transfer.
  assign v2       = vld[LAT-1];
  assign stall    = v2 & ~out_ready;
  assign adv      = ~stall;
  assign bram_en  = adv;
  assign bram_rst = rst;

  assign in_ready = adv & (state_q == RUN) & (issued < NB5);
  assign accept   = in_valid & in_ready;

  // Each share addresses its own port; the shares never meet in logic here.
  assign addra = {in_tsel, in_sh0};
  assign addrb = {in_tsel, in_sh1};

  assign out_valid = v2;
  assign out_sh0   = doa;
  assign out_sh1   = dob;
  assign out_idx   = idx_pipe[LAT-1];
  assign out_last  = v2 & (idx_pipe[LAT-1] == LAST_IDX);
  assign out_hs    = v2 & out_ready;

  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;
  assign dbg_issued = issued;

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (accept && (issued == NB5 - 5'd1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (out_hs && out_last) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      issued  <= 5'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        issued <= 5'd0;
      end else if (accept) begin
        issued <= issued + 5'd1;
      end
    end
  end

  // Valid/index shadow of the BRAM address and output registers; frozen with
  // bram_en so the payload stays aligned with the frozen read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int k = 0; k < LAT; k++) idx_pipe[k] <= 4'd0;
    end else if (adv) begin
      vld         <= {vld[LAT-2:0], accept};
      idx_pipe[0] <= issued[3:0];
      for (int k = 1; k < LAT; k++) idx_pipe[k] <= idx_pipe[k-1];
    end
  end

`ifndef SYNTHESIS
  a_issued_bounded : assert property (@(posedge clk) disable iff (rst) issued <= NB5);
  a_stall_holds    : assert property (@(posedge clk) disable iff (rst)
                                      stall |=> (v2 && $stable(idx_pipe[LAT-1])));
`endif

endmodule

// File: tb/tb_sbox_bram_feeder.sv
// Bench for sbox_bram_feeder: linear S-box BRAM model, directed batches and a
// scoreboard of expected output bytes.
module tb_sbox_bram_feeder;

  localparam int NB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_sh0;
  logic [7:0] in_sh1;
  logic [1:0] in_tsel;
  logic [9:0] addra;
  logic [9:0] addrb;
  logic       bram_en;
  logic       bram_rst;
  logic [7:0] doa;
  logic [7:0] dob;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sh0;
  logic [7:0] out_sh1;
  logic [3:0] out_idx;
  logic       out_last;
  logic [1:0] dbg_state;
  logic [4:0] dbg_issued;

  sbox_bram_feeder #(.NBYTES(NB), .LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_sh0(in_sh0), .in_sh1(in_sh1),
    .in_tsel(in_tsel), .addra(addra), .addrb(addrb), .bram_en(bram_en),
    .bram_rst(bram_rst), .doa(doa), .dob(dob), .out_valid(out_valid),
    .out_ready(out_ready), .out_sh0(out_sh0), .out_sh1(out_sh1),
    .out_idx(out_idx), .out_last(out_last), .dbg_state(dbg_state),
    .dbg_issued(dbg_issued)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- S-box reference and BRAM model ----------------
  function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
    return (a << n) | (a >> (8 - n));
  endfunction

  // GF(2)-linear table so that S(a) ^ S(b) = S(a ^ b) for the share check.
  function automatic logic [7:0] lin_sbox(input logic [1:0] t, input logic [7:0] x);
    return rotl(x, int'(t) + 1) ^ x;
  endfunction

  logic [7:0] mem [1024];
  logic [9:0] ra;
  logic [9:0] rb;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = lin_sbox(2'(i >> 8), 8'(i));
  end

  always @(posedge clk) begin
    if (bram_en) begin
      ra <= addra;
      rb <= addrb;
    end
    if (bram_rst) begin
      doa <= 8'h00;
      dob <= 8'h00;
    end else if (bram_en) begin
      doa <= mem[ra];
      dob <= mem[rb];
    end
  end

  // ---------------- output ready driver ----------------
  int stall_at = -1;
  always @(posedge clk) begin
    #1;
    out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
  end

  // ---------------- scoreboard ----------------
  logic [27:0] exp_q[$];
  int          lat_q[$];
  bit          lat_chk = 1'b0;
  int          n_acc = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;

  always @(negedge clk) begin
    logic [27:0] e;
    int          acc_c;
    bit          exp_done;
    exp_done = 1'b0;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got idx=%0d sh0=%h sh1=%h expected no output (cycle %0d)",
                 out_idx, out_sh0, out_sh1, cyc);
      end else begin
        e     = exp_q.pop_front();
        acc_c = lat_q.pop_front();
        chk("out_data", {out_idx, out_sh0, out_sh1, out_sh0 ^ out_sh1}, e);
        chk("out_last", out_last, (e[27:24] == 4'(NB - 1)));
        if (lat_chk) chk("latency", cyc - acc_c, 2);
        exp_done = (e[27:24] == 4'(NB - 1));
      end
    end
    if ((out_valid === 1'b1 && out_ready === 1'b1) || done === 1'b1) chk("done", done, exp_done);
    if (done === 1'b1) done_cyc = cyc;
  end

  always @(negedge clk) begin
    if (stall_at >= 0 && out_ready === 1'b0) begin
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_hold", {out_valid, out_idx, out_sh0, out_sh1}, {1'b1, 4'd4, 8'h0C, 8'h00});
    end
  end

  // ---------------- driver tasks ----------------
  logic [1:0] b_t  [NB];
  logic [7:0] b_s0 [NB];
  logic [7:0] b_s1 [NB];
  logic [7:0] b_e0 [NB];
  logic [7:0] b_e1 [NB];
  logic [7:0] b_rf [NB];

  task automatic fill_stream();
    for (int i = 0; i < NB; i++) begin
      b_t[i]  = 2'd0;
      b_s0[i] = 8'(i);
      b_s1[i] = 8'h00;
      b_e0[i] = lin_sbox(2'd0, 8'(i));
      b_e1[i] = 8'h00;
      b_rf[i] = lin_sbox(2'd0, 8'(i));
    end
  endtask

  task automatic fill_shares(input int base);
    for (int i = 0; i < NB; i++) begin
      logic [7:0] x;
      logic [7:0] m;
      logic [1:0] t;
      x = 8'(base + i);
      m = 8'($urandom_range(0, 255));
      t = 2'($urandom_range(0, 3));
      b_t[i]  = t;
      b_s0[i] = x ^ m;
      b_s1[i] = m;
      b_e0[i] = lin_sbox(t, x ^ m);
      b_e1[i] = lin_sbox(t, m);
      b_rf[i] = lin_sbox(t, x);
    end
  endtask

  task automatic start_batch();
    @(posedge clk); #1;
    start = 1'b1;
    n_acc = 0;
    @(negedge clk);
    start_cyc = cyc;
  endtask

  task automatic feed(input int first, input int n, input bit gapped, input bit hold_start);
    for (int i = first; i < n; i++) begin
      bit got;
      int waited;
      got    = 1'b0;
      waited = 0;
      if (gapped) begin
        @(posedge clk); #1;
        start    = hold_start;
        in_valid = 1'b0;
        in_sh0   = 8'($urandom_range(0, 255));
        in_sh1   = 8'($urandom_range(0, 255));
        in_tsel  = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
      @(posedge clk); #1;
      start    = hold_start;
      in_valid = 1'b1;
      in_tsel  = b_t[i];
      in_sh0   = b_s0[i];
      in_sh1   = b_s1[i];
      while (!got && waited < 40) begin
        @(negedge clk);
        if (in_ready === 1'b1) begin
          got = 1'b1;
          exp_q.push_back({4'(n_acc), b_e0[i], b_e1[i], b_rf[i]});
          lat_q.push_back(cyc);
          n_acc++;
        end else begin
          waited++;
          @(posedge clk); #1;
        end
      end
      if (!got) begin
        checks++;
        failures++;
        $display("FAIL feed_timeout: got no accept for byte %0d, expected accept within 40 cycles", i);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", {busy, 1'(exp_q.size() == 0)}, 2'b01);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0] t;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [9:0] ea;
    logic [9:0] eb;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t vt [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within 1 ms");
    $fatal(1);
  end

  initial begin
    vt[0] = '{t: 2'd0, s0: 8'h00, s1: 8'hFF, ea: 10'h000, eb: 10'h0FF, e0: 8'h00, e1: 8'h00};
    vt[1] = '{t: 2'd1, s0: 8'hA5, s1: 8'h3C, ea: 10'h1A5, eb: 10'h13C, e0: 8'h33, e1: 8'hCC};
    vt[2] = '{t: 2'd2, s0: 8'h7E, s1: 8'h81, ea: 10'h27E, eb: 10'h281, e0: 8'h8D, e1: 8'h8D};
    vt[3] = '{t: 2'd3, s0: 8'hFF, s1: 8'h00, ea: 10'h3FF, eb: 10'h300, e0: 8'h00, e1: 8'h00};
    vt[4] = '{t: 2'd2, s0: 8'h12, s1: 8'h34, ea: 10'h212, eb: 10'h234, e0: 8'h82, e1: 8'h95};
    vt[5] = '{t: 2'd1, s0: 8'h80, s1: 8'h01, ea: 10'h180, eb: 10'h101, e0: 8'h82, e1: 8'h05};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    in_sh0 = 8'h00; in_sh1 = 8'h00; in_tsel = 2'd0;

    // reset values, during and after reset
    @(negedge clk);
    chk("rst_ctrl", {busy, done, in_ready, out_valid, out_last, bram_rst}, 6'b000001);
    chk("rst_shares", {out_sh0, out_sh1}, 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ctrl", {busy, done, in_ready, out_valid, out_last, bram_rst}, 6'b000000);
    chk("post_rst_shares", {out_sh0, out_sh1}, 16'h0000);
    chk("post_rst_state", {dbg_state, dbg_issued}, 7'd0);

    // combinational addressing from the vector table
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      in_tsel = vt[i].t; in_sh0 = vt[i].s0; in_sh1 = vt[i].s1;
      @(negedge clk);
      chk("addr_vec", {addra, addrb}, {vt[i].ea, vt[i].eb});
    end
    chk("idle_in_ready", in_ready, 1'b0);

    // table vectors through the BRAM, hand-computed share outputs
    for (int i = 0; i < NB; i++) begin
      b_t[i]  = vt[i % 6].t;
      b_s0[i] = vt[i % 6].s0;
      b_s1[i] = vt[i % 6].s1;
      b_e0[i] = vt[i % 6].e0;
      b_e1[i] = vt[i % 6].e1;
      b_rf[i] = vt[i % 6].e0 ^ vt[i % 6].e1;
    end
    lat_chk = 1'b1;
    start_batch();
    feed(0, NB, 1'b0, 1'b0);
    wait_idle();

    // streaming batch: in_sh0 = i, in_sh1 = 0
    fill_stream();
    start_batch();
    feed(0, NB, 1'b0, 1'b0);
    wait_idle();
    chk("stream_time", done_cyc - start_cyc, 18);
    chk("stream_idle", dbg_state, 2'd0);

    // share check over all 256 x with random masks
    for (int b = 0; b < 16; b++) begin
      fill_shares(b * 16);
      start_batch();
      feed(0, NB, 1'b0, 1'b0);
      wait_idle();
    end

    // backpressure: out_ready low for 3 cycles while idx 4 is presented
    fill_stream();
    lat_chk = 1'b0;
    start_batch();
    stall_at = start_cyc + 7;
    feed(0, NB, 1'b0, 1'b0);
    wait_idle();
    stall_at = -1;
    chk("stall_time", done_cyc - start_cyc, 21);

    // gapped input with garbage addresses between valid bytes
    fill_shares(8'h5A);
    lat_chk = 1'b1;
    start_batch();
    feed(0, NB, 1'b1, 1'b0);
    wait_idle();

    // reset after 7 accepts, then a fresh full batch
    fill_stream();
    start_batch();
    feed(0, 7, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    lat_q.delete();
    n_acc = 0;
    @(negedge clk);
    chk("midrst_quiet", {out_valid, busy}, 2'b00);
    repeat (4) @(negedge clk);
    start_batch();
    feed(0, NB, 1'b0, 1'b0);
    wait_idle();

    // start held through RUN and DRAIN, and raised on the done cycle
    fill_stream();
    start_batch();
    feed(0, 5, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("run_start_ignored", dbg_issued, 5'd5);
    feed(5, NB, 1'b0, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    start = 1'b1;
    @(negedge clk);
    chk("done_cycle", done, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_start_ignored", {busy, dbg_state}, 3'b000);
    chk("issued_kept", dbg_issued, 5'd16);
    repeat (3) @(negedge clk);
    chk("stays_idle", busy, 1'b0);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sbox_bram_feeder.md
SBOX_BRAM_FEEDER -- requirements
Module: sbox_bram_feeder

Interface
REQ-001 Parameter: NBYTES, 16, number of masked bytes per S-box batch (2..16).
REQ-002 Parameter: LAT, 2, fixed read latency of the downstream BRAM (address register plus output register); only value 2 is supported.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  begins a batch; sampled only in IDLE.
REQ-006 busy  out  1  high in RUN or DRAIN.
REQ-007 done  out  1  one-cycle pulse on the final output handshake of a batch.
REQ-008 in_valid / in_ready  in / out  1 / 1  input byte handshake.
REQ-009 in_sh0, in_sh1  in  8 / 8  Boolean shares of the masked byte.
REQ-010 in_tsel  in  2  table-select field (upper address bits).
REQ-011 addra, addrb  out  10 / 10  BRAM port A/B read addresses.
REQ-012 bram_en  out  1  drives BRAM ENA, ENB, REGCEA and REGCEB.
REQ-013 bram_rst  out  1  drives BRAM RSTA and RSTB.
REQ-014 doa, dob  in  8 / 8  BRAM port A/B read data.
REQ-015 out_valid / out_ready  out / in  1 / 1  output byte handshake.
REQ-016 out_sh0, out_sh1  out  8 / 8  S-box output shares.
REQ-017 out_idx  out  4  byte index in the batch, 0..NBYTES-1.
REQ-018 out_last  out  1  high with out_valid when out_idx = NBYTES-1.

Function
REQ-019 addra = {in_tsel, in_sh0} and addrb = {in_tsel, in_sh1}, both combinational; the two shares are never combined in any gate.
REQ-020 stall = v2 & ~out_ready; adv = ~stall; bram_en = adv; bram_rst = rst.
REQ-021 in_ready = adv & (state = RUN) & (issued < NBYTES); accept = in_valid & in_ready.
REQ-022 When adv is high: v1 <= accept, idx1 <= issued, v2 <= v1, idx2 <= idx1. When adv is low, v1, v2, idx1 and idx2 hold their values.
REQ-023 out_valid = v2; out_sh0 = doa; out_sh1 = dob; out_idx = idx2; out_last = v2 & (idx2 = NBYTES-1).
REQ-024 Latency: a byte accepted in cycle t appears on out_valid in cycle t+2 when there is no stall, and each stall cycle adds exactly one cycle.
REQ-025 Throughput: one byte per cycle while in_valid and out_ready stay high.
REQ-026 issued is a 5-bit counter, cleared on the IDLE->RUN transition and incremented on each accept. It never exceeds NBYTES.
REQ-027 FSM IDLE: start -> RUN. RUN: accept with issued = NBYTES-1 -> DRAIN. DRAIN: out_valid & out_ready & out_last -> IDLE with done = 1.
REQ-028 start is ignored in RUN and DRAIN. start asserted on the same cycle as done is ignored, because the FSM is not yet in IDLE.
REQ-029 Addresses presented while accept = 0 still read the BRAM, but their data is never marked valid.
REQ-030 When out_ready drops with v2 = 1, out_sh0, out_sh1 and out_idx stay stable until the handshake completes, because the BRAM output register is frozen through bram_en.

Reset
REQ-031 While rst = 1 on a clock edge: state = IDLE, issued = 0, v1 = v2 = 0, idx1 = idx2 = 0.
REQ-032 During and after reset: busy = 0, done = 0, in_ready = 0, out_valid = 0, out_last = 0; bram_rst = 1 forces doa and dob to 0, so out_sh0 = out_sh1 = 0.
REQ-033 Reset mid-batch discards all in-flight bytes. No output handshake or done pulse follows until a new start.

Verification
REQ-034 Streaming: start, then 16 bytes with in_sh0 = i, in_sh1 = 0x00, in_tsel = 0 and out_ready = 1 -> 16 outputs, each 2 cycles after its accept, out_idx 0..15, out_last and done together on byte 15, then IDLE.
REQ-035 Share check: for all 256 x, send in_sh0 = x ^ m and in_sh1 = m with random m -> out_sh0 ^ out_sh1 equals the reference lookup result for x.
REQ-036 Backpressure: out_ready low for 3 cycles while out_valid = 1 at idx 4 -> in_ready = 0, outputs stable for those 3 cycles, no byte lost or duplicated, total batch time grows by 3 cycles.
REQ-037 Gapped input: in_valid toggles every cycle -> only accepted bytes are output, in order, and garbage reads are never marked valid.
REQ-038 Reset mid-batch: rst for 1 cycle after 7 accepts -> out_valid = 0 and busy = 0 the next cycle; a new start then gives a full 16-byte batch with out_idx starting at 0.
REQ-039 start during RUN, and start on the done cycle -> both ignored, issued is not cleared, FSM returns to IDLE.
